// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared types and helpers for the per-input-port VC arbiter.
//   arb_state_e  : arbiter FSM state encoding (IDLE / REQ / GRANTED)
//   N            : VC count for the default configuration (3 VCs x 2 classes)
//   idx_w()      : index width helper, never returns 0 so single-entry
//                  configurations still get a legal 1-bit vector
package vc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANTED = 2'd2
  } arb_state_e;

  localparam int unsigned VC_NUM_DEF   = 32'd3;
  localparam int unsigned PRIO_NUM_DEF = 32'd2;
  localparam int unsigned N            = VC_NUM_DEF * PRIO_NUM_DEF;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_input_arbiter_rr_class_picker.sv
// rr_class_picker: combinational round-robin picker for one priority class.
// Ports:
//   elig_i  : eligibility bit per VC of this class
//   ptr_i   : class round-robin pointer (local VC index, < vc_num)
//   found_o : at least one VC of the class is eligible
//   idx_o   : local index of the first eligible VC at or after ptr_i (wrapping)
module rr_class_picker
  import vc_arb_pkg::*;
#(
  parameter int unsigned vc_num = 32'd3,
  parameter int unsigned ptr_w  = idx_w(vc_num)
) (
  input  logic [vc_num-1:0] elig_i,
  input  logic [ptr_w-1:0]  ptr_i,
  output logic              found_o,
  output logic [ptr_w-1:0]  idx_o
);

  logic [ptr_w-1:0] cand_s;

  // Scan vc_num positions starting at the pointer; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int k = 0; k < int'(vc_num); k++) begin
      cand_s  = ptr_w'((int'(ptr_i) + k) % int'(vc_num));
      idx_o   = (!found_o && elig_i[cand_s]) ? cand_s : idx_o;
      found_o = found_o | elig_i[cand_s];
    end
  end

endmodule

// File: rtl/vc_input_arbiter.sv
// vc_input_arbiter: per-input-port virtual-channel arbiter.
// Picks one eligible VC (has_packet high and non-zero destination), highest
// priority class first and round-robin inside the class, requests its
// destination from the switch allocator and holds the selection until the
// packet's last beat.
// Ports:
//   clk, resetn    : clock, asynchronous active-low reset
//   has_packet     : per-VC packet pending
//   dest_i         : per-VC one-hot destination (0 = invalid)
//   output_vc_i    : per-VC downstream VC
//   cts            : allocator grant for the current request
//   last           : final beat of the packet on selected_vc
//   selected_vc    : currently selected VC
//   o_req          : request to the allocator
//   o_req_dest     : latched destination
//   o_req_vc       : latched downstream VC
//   o_grant_active : packet transfer in progress
// Optional feature: define VC_ARB_BURST_EN to let one grant carry up to
// max_burst back-to-back packets from the same VC to the same destination.
module vc_input_arbiter
  import vc_arb_pkg::*;
#(
  parameter  int unsigned vc_num     = 32'd3,
  parameter  int unsigned prio_num   = 32'd2,
  parameter  int unsigned output_num = 32'd8,
  parameter  int unsigned max_burst  = 32'd2,
  localparam int unsigned NV         = vc_num * prio_num,
  localparam int unsigned SW         = idx_w(NV)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NV-1:0]         has_packet,
  input  logic [output_num-1:0] dest_i      [NV],
  input  logic [SW-1:0]         output_vc_i [NV],
  input  logic                  cts,
  input  logic                  last,
  output logic [SW-1:0]         selected_vc,
  output logic                  o_req,
  output logic [output_num-1:0] o_req_dest,
  output logic [SW-1:0]         o_req_vc,
  output logic                  o_grant_active
);

  localparam int unsigned PW = idx_w(vc_num);
  localparam int unsigned CW = idx_w(prio_num);

  arb_state_e        state_q;
  logic [PW-1:0]     ptr_q       [prio_num];
  logic [NV-1:0]     elig_s;
  logic [prio_num-1:0] cls_found_s;
  logic [PW-1:0]     cls_idx_s   [prio_num];
  logic              pick_found_s;
  logic [SW-1:0]     pick_vc_s;
  logic [CW-1:0]     sel_cls_s;
  logic [PW-1:0]     sel_loc_s;
  logic [PW-1:0]     ptr_next_s;
  logic              has_sel_s;
  logic              end_pkt_s;

  // Eligibility: pending packet with a valid destination.
  always_comb begin
    elig_s = '0;
    for (int v = 0; v < int'(NV); v++) begin
      elig_s[v] = has_packet[v] & (|dest_i[v]);
    end
  end

  for (genvar c = 0; c < int'(prio_num); c++) begin : g_cls
    rr_class_picker #(
      .vc_num (vc_num),
      .ptr_w  (PW)
    ) u_pick (
      .elig_i  (elig_s[c*vc_num +: vc_num]),
      .ptr_i   (ptr_q[c]),
      .found_o (cls_found_s[c]),
      .idx_o   (cls_idx_s[c])
    );
  end

  // Fixed priority across classes: later (higher) classes override lower ones.
  always_comb begin
    pick_found_s = 1'b0;
    pick_vc_s    = '0;
    for (int c = 0; c < int'(prio_num); c++) begin
      pick_vc_s    = cls_found_s[c] ? SW'(c * int'(vc_num) + int'(cls_idx_s[c])) : pick_vc_s;
      pick_found_s = pick_found_s | cls_found_s[c];
    end
  end

  // Class / local index of the held selection and its pointer successor.
  always_comb begin
    sel_cls_s  = CW'(int'(selected_vc) / int'(vc_num));
    sel_loc_s  = PW'(int'(selected_vc) % int'(vc_num));
    ptr_next_s = (int'(sel_loc_s) == int'(vc_num) - 1) ? {PW{1'b0}} : sel_loc_s + PW'(1);
    has_sel_s  = has_packet[selected_vc];
  end

`ifdef VC_ARB_BURST_EN
  localparam int unsigned BW = idx_w(max_burst + 32'd1);
  logic [BW-1:0] burst_q;
  logic          keep_s;

  // A last beat keeps the grant when the same VC has another packet to the
  // same output and the burst budget is not yet used up.
  always_comb begin
    keep_s    = has_sel_s && (dest_i[selected_vc] == o_req_dest) &&
                ((int'(burst_q) + 1) < int'(max_burst));
    end_pkt_s = last & ~keep_s;
  end
`else
  logic unused_burst_s;
  assign unused_burst_s = (max_burst != 32'd0);

  // Every last beat closes the grant.
  always_comb begin
    end_pkt_s = last;
  end
`endif

  // Arbiter FSM with registered outputs and per-class round-robin pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      selected_vc    <= '0;
      o_req          <= 1'b0;
      o_req_dest     <= '0;
      o_req_vc       <= '0;
      o_grant_active <= 1'b0;
      for (int c = 0; c < int'(prio_num); c++) begin
        ptr_q[c] <= '0;
      end
`ifdef VC_ARB_BURST_EN
      burst_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found_s) begin
            selected_vc <= pick_vc_s;
            o_req_dest  <= dest_i[pick_vc_s];
            o_req_vc    <= output_vc_i[pick_vc_s];
            o_req       <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // cts has precedence over a simultaneous withdraw or last.
          if (cts) begin
            o_req          <= 1'b0;
            o_grant_active <= 1'b1;
            state_q        <= GRANTED;
`ifdef VC_ARB_BURST_EN
            burst_q        <= '0;
`endif
          end else if (!has_sel_s) begin
            o_req   <= 1'b0;
            state_q <= IDLE;
          end
        end
        GRANTED: begin
          if (end_pkt_s) begin
            ptr_q[sel_cls_s] <= ptr_next_s;
            o_grant_active   <= 1'b0;
            state_q          <= IDLE;
          end
`ifdef VC_ARB_BURST_EN
          else if (last) begin
            burst_q <= burst_q + BW'(1);
          end
`endif
        end
        default: begin
          o_req          <= 1'b0;
          o_grant_active <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_input_arbiter.sv
// Directed self-checking bench for vc_input_arbiter (3 VCs x 2 classes,
// 8 outputs). Inputs change 1 time unit after the rising edge, outputs are
// sampled at the same point, i.e. after the edge has settled.
module tb_vc_input_arbiter;

  logic       clk;
  logic       resetn;
  logic [5:0] has_packet;
  logic [7:0] dest_i      [6];
  logic [2:0] output_vc_i [6];
  logic       cts;
  logic       last;
  logic [2:0] selected_vc;
  logic       o_req;
  logic [7:0] o_req_dest;
  logic [2:0] o_req_vc;
  logic       o_grant_active;

  int checks;
  int failures;
  int exp_order [4];

  vc_input_arbiter dut (
    .clk            (clk),
    .resetn         (resetn),
    .has_packet     (has_packet),
    .dest_i         (dest_i),
    .output_vc_i    (output_vc_i),
    .cts            (cts),
    .last           (last),
    .selected_vc    (selected_vc),
    .o_req          (o_req),
    .o_req_dest     (o_req_dest),
    .o_req_vc       (o_req_vc),
    .o_grant_active (o_grant_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn     = 1'b0;
    has_packet = 6'b0;
    cts        = 1'b0;
    last       = 1'b0;
    for (int v = 0; v < 6; v++) begin
      dest_i[v]      = 8'h00;
      output_vc_i[v] = 3'd0;
    end
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 0;

    // Reset state
    tick(); tick();
    chk("rst_req",   32'(o_req), 32'd0);
    chk("rst_gnt",   32'(o_grant_active), 32'd0);
    chk("rst_sel",   32'(selected_vc), 32'd0);
    chk("rst_dest",  32'(o_req_dest), 32'd0);
    chk("rst_vc",    32'(o_req_vc), 32'd0);
    resetn = 1'b1;

    // Single VC 4 (class 1)
    dest_i[4] = 8'h04; output_vc_i[4] = 3'd4; has_packet = 6'b010000;
    tick();
    chk("t1_req",  32'(o_req), 32'd1);
    chk("t1_dest", 32'(o_req_dest), 32'h04);
    chk("t1_vc",   32'(o_req_vc), 32'd4);
    chk("t1_sel",  32'(selected_vc), 32'd4);
    chk("t1_gnt0", 32'(o_grant_active), 32'd0);
    cts = 1'b1;
    tick();
    chk("t1_gnt",  32'(o_grant_active), 32'd1);
    chk("t1_req0", 32'(o_req), 32'd0);
    cts = 1'b0; last = 1'b1; has_packet = 6'b0;
    tick();
    chk("t1_idle_gnt", 32'(o_grant_active), 32'd0);
    chk("t1_idle_req", 32'(o_req), 32'd0);
    chk("t1_sel_hold", 32'(selected_vc), 32'd4);
    last = 1'b0;
    // class-1 pointer now at VC 5: with 3,4,5 pending VC 5 wins
    for (int v = 3; v < 6; v++) begin
      dest_i[v] = 8'h01; output_vc_i[v] = 3'(v);
    end
    has_packet = 6'b111000;
    tick();
    chk("t1_ptr5", 32'(selected_vc), 32'd5);
    chk("t1_ptr5_req", 32'(o_req), 32'd1);
    has_packet = 6'b0;
    tick();
    chk("t1_withdraw", 32'(o_req), 32'd0);

    // VCs 0,1,3 with cts held: order 3,0,1
    dest_i[0] = 8'h02; output_vc_i[0] = 3'd1;
    dest_i[1] = 8'h20; output_vc_i[1] = 3'd2;
    has_packet = 6'b001011; cts = 1'b1;
    tick();
    chk("t2_sel3",  32'(selected_vc), 32'd3);
    chk("t2_req3",  32'(o_req), 32'd1);
    chk("t2_dest3", 32'(o_req_dest), 32'h01);
    tick();
    chk("t2_gnt3", 32'(o_grant_active), 32'd1);
    last = 1'b1; has_packet = 6'b000011;
    tick();
    chk("t2_idle3", 32'(o_grant_active), 32'd0);
    chk("t2_bubble3", 32'(o_req), 32'd0);
    last = 1'b0;
    tick();
    chk("t2_sel0",  32'(selected_vc), 32'd0);
    chk("t2_req0",  32'(o_req), 32'd1);
    chk("t2_dest0", 32'(o_req_dest), 32'h02);
    chk("t2_vc0",   32'(o_req_vc), 32'd1);
    tick();
    chk("t2_gnt0", 32'(o_grant_active), 32'd1);
    last = 1'b1; has_packet = 6'b000010;
    tick();
    chk("t2_idle0", 32'(o_grant_active), 32'd0);
    last = 1'b0;
    tick();
    chk("t2_sel1",  32'(selected_vc), 32'd1);
    chk("t2_dest1", 32'(o_req_dest), 32'h20);
    tick();
    chk("t2_gnt1", 32'(o_grant_active), 32'd1);
    last = 1'b1; has_packet = 6'b0; cts = 1'b0;
    tick();
    chk("t2_idle1_gnt", 32'(o_grant_active), 32'd0);
    chk("t2_idle1_req", 32'(o_req), 32'd0);
    last = 1'b0;

    // Reset asserted during GRANTED
    has_packet = 6'b000010;
    tick();
    chk("t5_sel1", 32'(selected_vc), 32'd1);
    cts = 1'b1;
    tick();
    chk("t5_gnt", 32'(o_grant_active), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_gnt",  32'(o_grant_active), 32'd0);
    chk("t5_rst_req",  32'(o_req), 32'd0);
    chk("t5_rst_sel",  32'(selected_vc), 32'd0);
    chk("t5_rst_dest", 32'(o_req_dest), 32'd0);
    has_packet = 6'b0; cts = 1'b0;
    tick();
    resetn = 1'b1;

    // Withdraw VC 1 in REQ; class-0 pointer must stay at 0
    has_packet = 6'b000010;
    tick();
    chk("t5_wd_req", 32'(o_req), 32'd1);
    chk("t5_wd_sel", 32'(selected_vc), 32'd1);
    has_packet = 6'b0;
    tick();
    chk("t5_wd_idle", 32'(o_req), 32'd0);
    chk("t5_wd_hold", 32'(selected_vc), 32'd1);
    dest_i[2] = 8'h08; output_vc_i[2] = 3'd2;
    has_packet = 6'b000110;
    tick();
    chk("t5_ptr_kept", 32'(selected_vc), 32'd1);
    has_packet = 6'b0;
    tick();
    chk("t5_wd2_idle", 32'(o_req), 32'd0);

    // VCs 0,1,2 continuously pending: 0,1,2,0
    has_packet = 6'b000111; cts = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_req", 32'(o_req), 32'd1);
      chk("t3_sel", 32'(selected_vc), 32'(exp_order[i]));
      tick();
      chk("t3_gnt", 32'(o_grant_active), 32'd1);
      last = 1'b1;
`ifdef VC_ARB_BURST_EN
      tick();
      chk("t3_burst_keep", 32'(o_grant_active), 32'd1);
`endif
      if (i == 3) has_packet = 6'b0;
      tick();
      chk("t3_idle", 32'(o_grant_active), 32'd0);
      chk("t3_sel_stable", 32'(selected_vc), 32'(exp_order[i]));
      last = 1'b0;
    end
    cts = 1'b0;

    // VC 2 pending with invalid destination
    dest_i[2] = 8'h00; has_packet = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_no_req", 32'(o_req), 32'd0);
    end
    has_packet = 6'b0;
    tick();

    // VC 5 sends two packets to the same destination
    dest_i[5] = 8'h80; output_vc_i[5] = 3'd5; has_packet = 6'b100000;
    tick();
    chk("t6_sel5",  32'(selected_vc), 32'd5);
    chk("t6_dest5", 32'(o_req_dest), 32'h80);
    chk("t6_vc5",   32'(o_req_vc), 32'd5);
    cts = 1'b1;
    tick();
    chk("t6_gnt", 32'(o_grant_active), 32'd1);
    cts = 1'b0; last = 1'b1;
    tick();
`ifdef VC_ARB_BURST_EN
    chk("t6_keep_gnt", 32'(o_grant_active), 32'd1);
    chk("t6_keep_req", 32'(o_req), 32'd0);
    tick();
    chk("t6_end_gnt", 32'(o_grant_active), 32'd0);
    last = 1'b0; has_packet = 6'b0;
    tick();
    chk("t6_end_req", 32'(o_req), 32'd0);
`else
    chk("t6_end1_gnt", 32'(o_grant_active), 32'd0);
    last = 1'b0;
    tick();
    chk("t6_req2",  32'(o_req), 32'd1);
    chk("t6_sel2",  32'(selected_vc), 32'd5);
    tick();
    chk("t6_wait_cts_gnt", 32'(o_grant_active), 32'd0);
    chk("t6_wait_cts_req", 32'(o_req), 32'd1);
    cts = 1'b1;
    tick();
    chk("t6_gnt2", 32'(o_grant_active), 32'd1);
    cts = 1'b0; last = 1'b1; has_packet = 6'b0;
    tick();
    chk("t6_end2_gnt", 32'(o_grant_active), 32'd0);
    last = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
